// File: rtl/fetch_ctr_if.sv
// Handshake/control bundle for fetch_ctr: sequencing controls in, PC and stack status out.
interface fetch_ctr_if #(
  parameter int L = 10,
  parameter int D = 4
);
  localparam int DW = $clog2(D + 1);

  logic          Start;
  logic [L-1:0]  StartAddr;
  logic          Stall;
  logic          JmpEq;
  logic          JmpNe;
  logic          JmpAl;
  logic          Zero;
  logic          RelMode;
  logic [L-1:0]  DestAddr;
  logic          Call;
  logic          Ret;
  logic [L-1:0]  ProgCtr;
  logic          Taken;
  logic [DW-1:0] Depth;
  logic          StkErr;

  modport master (
    output Start, StartAddr, Stall, JmpEq, JmpNe, JmpAl, Zero, RelMode,
           DestAddr, Call, Ret,
    input  ProgCtr, Taken, Depth, StkErr
  );

  modport slave (
    input  Start, StartAddr, Stall, JmpEq, JmpNe, JmpAl, Zero, RelMode,
           DestAddr, Call, Ret,
    output ProgCtr, Taken, Depth, StkErr
  );
endinterface

// File: rtl/fetch_ctr.sv
// Program counter with branches, relative jumps and an optional return stack.
// Return stack is built only when FETCH_CTR_RSTACK_EN is defined.
module fetch_ctr #(
  parameter int L = 10,
  parameter int D = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  fetch_ctr_if.slave  bus
);
  localparam int DW = $clog2(D + 1);

  logic [L-1:0] pc_q;
  logic         taken_q;
  logic [L-1:0] pc_inc;
  logic [L-1:0] target;
  logic         cond_br;

  // Sign-extending an L-bit offset and adding modulo 2^L equals a plain L-bit add.
  always_comb begin
    pc_inc  = pc_q + L'(1);
    target  = bus.RelMode ? (pc_q + bus.DestAddr) : bus.DestAddr;
    cond_br = (bus.JmpEq & bus.Zero) | (bus.JmpNe & ~bus.Zero) | bus.JmpAl;
  end

`ifdef FETCH_CTR_RSTACK_EN
  localparam int AW = (D > 1) ? $clog2(D) : 1;

  logic [L-1:0]  stk [D];
  logic [DW-1:0] depth_q;
  logic          err_q;
  logic          stk_full;
  logic          stk_empty;
  logic          push;

  always_comb begin
    stk_full  = (depth_q == DW'(D));
    stk_empty = (depth_q == '0);
    push      = ~Reset & ~bus.Start & ~bus.Stall & ~bus.Ret & bus.Call & ~stk_full;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q    <= '0;
      taken_q <= 1'b0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else if (bus.Start) begin
      pc_q    <= bus.StartAddr;
      taken_q <= 1'b1;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else if (!bus.Stall) begin
      if (bus.Ret) begin
        if (bus.Call) err_q <= 1'b1;
        if (!stk_empty) begin
          pc_q    <= stk[AW'(depth_q - DW'(1))];
          depth_q <= depth_q - DW'(1);
          taken_q <= 1'b1;
        end else begin
          err_q   <= 1'b1;
          pc_q    <= pc_inc;
          taken_q <= 1'b0;
        end
      end else if (bus.Call) begin
        if (!stk_full) begin
          depth_q <= depth_q + DW'(1);
          pc_q    <= target;
          taken_q <= 1'b1;
        end else begin
          err_q   <= 1'b1;
          pc_q    <= pc_inc;
          taken_q <= 1'b0;
        end
      end else if (cond_br) begin
        pc_q    <= target;
        taken_q <= 1'b1;
      end else begin
        pc_q    <= pc_inc;
        taken_q <= 1'b0;
      end
    end
  end

  // Storage is never cleared; Depth alone defines which entries are live.
  always_ff @(posedge Clk) begin
    if (push) stk[AW'(depth_q)] <= pc_inc;
  end

  assign bus.Depth  = depth_q;
  assign bus.StkErr = err_q;
`else
  logic unused_ret;
  assign unused_ret = bus.Ret;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q    <= '0;
      taken_q <= 1'b0;
    end else if (bus.Start) begin
      pc_q    <= bus.StartAddr;
      taken_q <= 1'b1;
    end else if (!bus.Stall) begin
      if (cond_br | bus.Call) begin
        pc_q    <= target;
        taken_q <= 1'b1;
      end else begin
        pc_q    <= pc_inc;
        taken_q <= 1'b0;
      end
    end
  end

  assign bus.Depth  = '0;
  assign bus.StkErr = 1'b0;
`endif

  assign bus.ProgCtr = pc_q;
  assign bus.Taken   = taken_q;
endmodule

// File: tb/tb_fetch_ctr.sv
// Self-checking bench for fetch_ctr: directed scenarios plus randomized run against a queue-based model.
module tb_fetch_ctr;
  localparam int L   = 10;
  localparam int D   = 4;
  localparam int DW  = $clog2(D + 1);
  localparam int MOD = 1 << L;
`ifdef FETCH_CTR_RSTACK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset;
  fetch_ctr_if #(.L(L), .D(D)) bus ();
  fetch_ctr #(.L(L), .D(D)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  int m_pc;
  bit m_taken;
  bit m_err;
  int m_stk[$];

  task automatic idle();
    Reset         = 1'b0;
    bus.Start     = 1'b0;
    bus.StartAddr = '0;
    bus.Stall     = 1'b0;
    bus.JmpEq     = 1'b0;
    bus.JmpNe     = 1'b0;
    bus.JmpAl     = 1'b0;
    bus.Zero      = 1'b0;
    bus.RelMode   = 1'b0;
    bus.DestAddr  = '0;
    bus.Call      = 1'b0;
    bus.Ret       = 1'b0;
  endtask

  function automatic int target_of();
    int off;
    off = int'(bus.DestAddr);
    if (!bus.RelMode) return off;
    if (off >= MOD / 2) off = off - MOD;
    return (m_pc + off + MOD) % MOD;
  endfunction

  task automatic model_inc();
    m_pc    = (m_pc + 1) % MOD;
    m_taken = 1'b0;
  endtask

  // Advance model from current inputs, then let the DUT take the same edge.
  task automatic step();
    if (Reset) begin
      m_pc = 0; m_taken = 0; m_err = 0; m_stk.delete();
    end else if (bus.Start) begin
      m_pc = int'(bus.StartAddr); m_taken = 1; m_err = 0; m_stk.delete();
    end else if (!bus.Stall) begin
      int t;
      bit br;
      t  = target_of();
      br = (bus.JmpEq && bus.Zero) || (bus.JmpNe && !bus.Zero) || bus.JmpAl;
      if (EN) begin
        if (bus.Ret) begin
          if (bus.Call) m_err = 1;
          if (m_stk.size() > 0) begin
            m_pc = m_stk.pop_back(); m_taken = 1;
          end else begin
            m_err = 1; model_inc();
          end
        end else if (bus.Call) begin
          if (m_stk.size() < D) begin
            m_stk.push_back((m_pc + 1) % MOD); m_pc = t; m_taken = 1;
          end else begin
            m_err = 1; model_inc();
          end
        end else if (br) begin
          m_pc = t; m_taken = 1;
        end else model_inc();
      end else begin
        if (br || bus.Call) begin
          m_pc = t; m_taken = 1;
        end else model_inc();
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    Reset = 1; bus.Start = 1; bus.StartAddr = 10'h155; bus.Stall = 1;
    step(); step();
    checks++; if (bus.ProgCtr !== 10'h000) begin errors++; $display("FAIL reset_pc got %h exp 000", bus.ProgCtr); end
    checks++; if (bus.Taken !== 1'b0) begin errors++; $display("FAIL reset_taken got %b exp 0", bus.Taken); end
    checks++; if (bus.Depth !== DW'(0)) begin errors++; $display("FAIL reset_depth got %0d exp 0", bus.Depth); end
    checks++; if (bus.StkErr !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.StkErr); end
    idle();
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++; if (bus.ProgCtr !== L'(i)) begin errors++; $display("FAIL idle_pc got %h exp %h", bus.ProgCtr, L'(i)); end
      checks++; if (bus.Taken !== 1'b0) begin errors++; $display("FAIL idle_taken got %b exp 0", bus.Taken); end
    end
  endtask

  task automatic test_wrap_rel();
    idle(); bus.Start = 1; bus.StartAddr = 10'h3FF; step();
    checks++; if (bus.ProgCtr !== 10'h3FF || bus.Taken !== 1'b1) begin errors++; $display("FAIL start_pc got %h/%b exp 3ff/1", bus.ProgCtr, bus.Taken); end
    idle(); step();
    checks++; if (bus.ProgCtr !== 10'h000 || bus.Taken !== 1'b0) begin errors++; $display("FAIL wrap_pc got %h/%b exp 000/0", bus.ProgCtr, bus.Taken); end
    bus.Start = 1; bus.StartAddr = 10'h010; step();
    idle(); bus.RelMode = 1; bus.DestAddr = 10'h3FC; bus.JmpAl = 1; step();
    checks++; if (bus.ProgCtr !== 10'h00C || bus.Taken !== 1'b1) begin errors++; $display("FAIL rel_back got %h/%b exp 00c/1", bus.ProgCtr, bus.Taken); end
    idle(); bus.Start = 1; bus.StartAddr = 10'h3F0; step();
    idle(); bus.RelMode = 1; bus.DestAddr = 10'h020; bus.JmpAl = 1; step();
    checks++; if (bus.ProgCtr !== 10'h010) begin errors++; $display("FAIL rel_fwd_wrap got %h exp 010", bus.ProgCtr); end
  endtask

  task automatic test_cond();
    idle(); bus.Start = 1; bus.StartAddr = 10'h020; step();
    idle(); bus.JmpEq = 1; bus.Zero = 0; bus.DestAddr = 10'h100; step();
    checks++; if (bus.ProgCtr !== 10'h021 || bus.Taken !== 1'b0) begin errors++; $display("FAIL je_not_taken got %h/%b exp 021/0", bus.ProgCtr, bus.Taken); end
    idle(); bus.JmpNe = 1; bus.Zero = 0; bus.DestAddr = 10'h100; step();
    checks++; if (bus.ProgCtr !== 10'h100 || bus.Taken !== 1'b1) begin errors++; $display("FAIL jne_taken got %h/%b exp 100/1", bus.ProgCtr, bus.Taken); end
    idle(); bus.JmpEq = 1; bus.Zero = 1; bus.DestAddr = 10'h155; step();
    checks++; if (bus.ProgCtr !== 10'h155) begin errors++; $display("FAIL je_taken got %h exp 155", bus.ProgCtr); end
    idle(); bus.JmpNe = 1; bus.Zero = 1; bus.DestAddr = 10'h2AA; step();
    checks++; if (bus.ProgCtr !== 10'h156) begin errors++; $display("FAIL jne_not_taken got %h exp 156", bus.ProgCtr); end
  endtask

  task automatic test_call_ret();
    idle(); bus.Start = 1; bus.StartAddr = 10'h040; step();
    idle(); bus.Call = 1; bus.DestAddr = 10'h200; step();
    checks++; if (bus.ProgCtr !== 10'h200 || bus.Depth !== DW'(EN ? 1 : 0)) begin errors++; $display("FAIL call1 got %h d%0d", bus.ProgCtr, bus.Depth); end
    idle(); repeat (5) step();
    bus.Call = 1; bus.DestAddr = 10'h300; step();
    checks++; if (bus.ProgCtr !== 10'h300 || bus.Depth !== DW'(EN ? 2 : 0)) begin errors++; $display("FAIL call2 got %h d%0d", bus.ProgCtr, bus.Depth); end
    idle(); bus.Ret = 1; step();
    checks++; if (bus.ProgCtr !== (EN ? 10'h206 : 10'h301) || bus.Depth !== DW'(EN ? 1 : 0)) begin errors++; $display("FAIL ret1 got %h d%0d", bus.ProgCtr, bus.Depth); end
    step();
    checks++; if (bus.ProgCtr !== (EN ? 10'h041 : 10'h302) || bus.Depth !== DW'(0) || bus.Taken !== EN) begin errors++; $display("FAIL ret2 got %h d%0d t%b", bus.ProgCtr, bus.Depth, bus.Taken); end
  endtask

  task automatic test_overflow();
    logic [L-1:0] pops [4];
    pops[0] = 10'h101; pops[1] = 10'h101; pops[2] = 10'h101; pops[3] = 10'h001;
    idle(); bus.Start = 1; bus.StartAddr = 10'h000; step();
    idle(); bus.Call = 1; bus.DestAddr = 10'h100;
    for (int i = 1; i <= 4; i++) step();
    checks++; if (bus.Depth !== DW'(EN ? 4 : 0) || bus.StkErr !== 1'b0 || bus.ProgCtr !== 10'h100) begin errors++; $display("FAIL four_calls got %h d%0d e%b", bus.ProgCtr, bus.Depth, bus.StkErr); end
    step();
    checks++; if (bus.ProgCtr !== (EN ? 10'h101 : 10'h100) || bus.Depth !== DW'(EN ? 4 : 0) || bus.StkErr !== EN) begin errors++; $display("FAIL overflow got %h d%0d e%b", bus.ProgCtr, bus.Depth, bus.StkErr); end
    if (EN) begin
      idle(); bus.Ret = 1;
      for (int i = 0; i < 4; i++) begin
        step();
        checks++; if (bus.ProgCtr !== pops[i] || bus.Depth !== DW'(3 - i)) begin errors++; $display("FAIL pop%0d got %h d%0d exp %h d%0d", i, bus.ProgCtr, bus.Depth, pops[i], 3 - i); end
      end
      step();
      checks++; if (bus.ProgCtr !== 10'h002 || bus.StkErr !== 1'b1 || bus.Taken !== 1'b0) begin errors++; $display("FAIL underflow got %h e%b t%b exp 002 1 0", bus.ProgCtr, bus.StkErr, bus.Taken); end
    end
    idle(); bus.Start = 1; bus.StartAddr = 10'h080; step();
    checks++; if (bus.ProgCtr !== 10'h080 || bus.Depth !== DW'(0) || bus.StkErr !== 1'b0) begin errors++; $display("FAIL start_clear got %h d%0d e%b", bus.ProgCtr, bus.Depth, bus.StkErr); end
    if (EN) begin
      idle(); bus.Call = 1; bus.DestAddr = 10'h030; step();
      bus.Ret = 1; bus.DestAddr = 10'h077; step();
      checks++; if (bus.ProgCtr !== 10'h081 || bus.Depth !== DW'(0) || bus.StkErr !== 1'b1 || bus.Taken !== 1'b1) begin errors++; $display("FAIL call_ret got %h d%0d e%b t%b exp 081 0 1 1", bus.ProgCtr, bus.Depth, bus.StkErr, bus.Taken); end
    end
  endtask

  task automatic test_stall();
    idle(); bus.Start = 1; bus.StartAddr = 10'h123; step();
    idle(); bus.Call = 1; bus.DestAddr = 10'h050; step();
    idle(); bus.Stall = 1; bus.JmpAl = 1; bus.Call = 1; bus.Ret = 1; bus.DestAddr = 10'h3AA;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.ProgCtr !== 10'h050 || bus.Taken !== 1'b1 || bus.Depth !== DW'(EN ? 1 : 0) || bus.StkErr !== 1'b0) begin errors++; $display("FAIL stall got %h t%b d%0d e%b", bus.ProgCtr, bus.Taken, bus.Depth, bus.StkErr); end
    end
    idle(); Reset = 1; bus.Start = 1; bus.StartAddr = 10'h2AA; step();
    checks++; if (bus.ProgCtr !== 10'h000 || bus.Taken !== 1'b0 || bus.Depth !== DW'(0)) begin errors++; $display("FAIL reset_over_start got %h t%b d%0d", bus.ProgCtr, bus.Taken, bus.Depth); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      idle();
      Reset         = ($urandom_range(0, 59) == 0);
      bus.Start     = ($urandom_range(0, 29) == 0);
      bus.StartAddr = L'($urandom);
      bus.Stall     = ($urandom_range(0, 7) == 0);
      bus.JmpEq     = $urandom_range(0, 1);
      bus.JmpNe     = $urandom_range(0, 1);
      bus.JmpAl     = ($urandom_range(0, 3) == 0);
      bus.Zero      = $urandom_range(0, 1);
      bus.RelMode   = $urandom_range(0, 1);
      bus.DestAddr  = L'($urandom);
      bus.Call      = ($urandom_range(0, 3) == 0);
      bus.Ret       = ($urandom_range(0, 4) == 0);
      if (!EN && (bus.Call || bus.JmpEq || bus.JmpNe || bus.JmpAl)) bus.Ret = 0;
      step();
      checks++; if (bus.ProgCtr !== L'(m_pc)) begin errors++; $display("FAIL rand_pc n%0d got %h exp %h", n, bus.ProgCtr, L'(m_pc)); end
      checks++; if (bus.Taken !== m_taken) begin errors++; $display("FAIL rand_taken n%0d got %b exp %b", n, bus.Taken, m_taken); end
      checks++; if (bus.Depth !== DW'(m_stk.size())) begin errors++; $display("FAIL rand_depth n%0d got %0d exp %0d", n, bus.Depth, m_stk.size()); end
      checks++; if (bus.StkErr !== m_err) begin errors++; $display("FAIL rand_err n%0d got %b exp %b", n, bus.StkErr, m_err); end
    end
  endtask

  initial begin
    m_pc = 0; m_taken = 0; m_err = 0;
    idle();
    test_reset();
    test_wrap_rel();
    test_cond();
    test_call_ret();
    test_overflow();
    test_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_ctr.md
FETCH_CTR -- requirements
Module: fetch_ctr

Interface
REQ-001 Parameter L, default 10: program-counter and address width in bits.
REQ-002 Parameter D, default 4: return-stack depth in entries, D >= 1.
REQ-003 Clk  in  1  single clock; all state SHALL change on posedge Clk only.
REQ-004 Reset  in  1  reset is synchronous and active-high; it forces the block to its reset state.
REQ-005 Start  in  1  load StartAddr into the PC; begins the next program.
REQ-006 StartAddr  in  L  entry address of the next program.
REQ-007 Stall  in  1  hold all state.
REQ-008 JmpEq  in  1  je: branch if Zero = 1.
REQ-009 JmpNe  in  1  jne: branch if Zero = 0.
REQ-010 JmpAl  in  1  unconditional jump.
REQ-011 Zero  in  1  ALU zero flag.
REQ-012 RelMode  in  1  0 = DestAddr is absolute; 1 = DestAddr is a signed two's-complement offset from the PC.
REQ-013 DestAddr  in  L  branch target or offset.
REQ-014 Call  in  1  push PC+1, then jump to the target.
REQ-015 Ret  in  1  pop the return address into the PC.
REQ-016 ProgCtr  out  L  program counter register.
REQ-017 Taken  out  1  registered; 1 when the last update was non-sequential (Start, jump, Call or Ret).
REQ-018 Depth  out  $clog2(D+1)  current return-stack occupancy.
REQ-019 StkErr  out  1  sticky stack overflow/underflow flag.

Function
REQ-020 Each cycle SHALL apply exactly one action, in this priority order: Reset > Start > Stall > Ret > Call > taken branch > increment.
REQ-021 Start: ProgCtr <= StartAddr; Taken <= 1; the stack SHALL be emptied (Depth <= 0); StkErr SHALL be cleared.
REQ-022 Stall: ProgCtr, stack, Depth, Taken and StkErr SHALL hold; all branch, Call and Ret inputs are ignored.
REQ-023 Target = DestAddr when RelMode = 0; otherwise ProgCtr + sign-extended DestAddr, modulo 2^L.
REQ-024 A branch is taken if (JmpEq & Zero) | (JmpNe & !Zero) | JmpAl; if taken, ProgCtr <= Target and Taken <= 1.
REQ-025 Increment: ProgCtr <= ProgCtr + 1, modulo 2^L (2^L-1 wraps to 0); Taken <= 0.
REQ-026 Call with Depth < D: push (ProgCtr + 1) mod 2^L; Depth += 1; ProgCtr <= Target; Taken <= 1.
REQ-027 Call with Depth = D (overflow): no push, no jump; StkErr <= 1; increment per REQ-025.
REQ-028 Ret with Depth > 0: ProgCtr <= top of stack; Depth -= 1; Taken <= 1.
REQ-029 Ret with Depth = 0 (underflow): StkErr <= 1; increment per REQ-025.
REQ-030 Call and Ret asserted together: Ret SHALL win and StkErr <= 1.
REQ-031 Branch inputs asserted together with Call or Ret SHALL be ignored, except as Call's target source.
REQ-032 Stack storage is LIFO; entries at index >= Depth are don't-care and SHALL NOT be observable.
REQ-033 Latency: every action SHALL be visible on ProgCtr one cycle after the triggering edge; no combinational path from inputs to outputs.

Reset
REQ-034 Reset SHALL apply ProgCtr = 0, Taken = 0, Depth = 0 and StkErr = 0 on the next posedge, overriding Start, Stall and all other inputs.
REQ-035 Reset during a call sequence SHALL discard all stack contents; stack storage itself need not be cleared.

Configuration
REQ-036 Macro FETCH_CTR_RSTACK_EN defined: Call, Ret, Depth and StkErr SHALL behave per REQ-026 to REQ-030.
REQ-037 Macro FETCH_CTR_RSTACK_EN undefined: no stack storage SHALL be built; Call SHALL act as JmpAl with no push; Ret SHALL be ignored (increment); Depth and StkErr SHALL be tied to 0.

Verification
REQ-038 Reset, then 5 idle cycles -> ProgCtr = 0,1,2,3,4,5; Taken = 0 throughout.
REQ-039 From PC 0x3FF, increment -> ProgCtr = 0x000; then at PC 0x010, RelMode = 1, DestAddr = 0x3FC (-4), JmpAl -> ProgCtr = 0x00C, Taken = 1.
REQ-040 JmpEq, Zero = 0, DestAddr = 0x100 at PC 0x020 -> PC 0x021; then JmpNe, Zero = 0 -> PC 0x100.
REQ-041 At PC 0x040, Call to 0x200 -> PC 0x200, Depth 1; nested Call from 0x205 to 0x300 -> Depth 2; Ret -> PC 0x206; Ret -> PC 0x041, Depth 0.
REQ-042 With D = 4: 5 consecutive Calls -> Depth 4, StkErr = 1, 5th Call increments the PC; then Ret on empty stack after 4 pops -> StkErr stays 1; Start with StartAddr = 0x080 -> PC 0x080, Depth 0, StkErr 0.
REQ-043 Stall held 3 cycles while JmpAl and Call asserted -> all outputs unchanged; Reset asserted together with Start -> ProgCtr = 0.
